// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: bus stores feed a TX FIFO that is
// drained onto out_tx, while loads return status and configuration.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int BAUD_DIV_RESET = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        in_sel,
  input  logic [1:0]  in_addr,
  input  logic        in_re_web,
  input  logic [31:0] in_write_data,
  input  logic [3:0]  in_byte_en,
  output logic [31:0] out_read_data,
  output logic        out_tx,
  output logic        out_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic [15:0]   baud_div_r;
  logic          tx_en_r;
  logic          irq_en_r;
  state_t        state_r;
  state_t        state_nx_s;
  logic [15:0]   baud_cnt_r;
  logic [15:0]   baud_cnt_nx_s;
  logic [2:0]    bit_cnt_r;
  logic [2:0]    bit_cnt_nx_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nx_s;
  logic          tx_r;
  logic          tx_nx_s;
  logic          irq_r;
  logic          irq_nx_s;

  logic          wr_s;
  logic          rd_s;
  logic          push_req_s;
  logic          push_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic          ovf_clr_s;
  logic          full_s;
  logic          empty_s;
  logic          busy_s;
  logic          bit_end_s;
  logic [7:0]    head_s;
  logic [15:0]   baud_merge_s;
  logic [15:0]   baud_wr_s;
  logic [31:0]   status_s;
  logic          unused_s;

  assign unused_s = ^in_write_data[31:16];

  assign out_tx  = tx_r;
  assign out_irq = irq_r;

  // Bus decode and FIFO handshake terms
  always_comb begin
    wr_s       = in_sel & ~in_re_web;
    rd_s       = in_sel & in_re_web;
    full_s     = (count_r == FULL_CNT);
    empty_s    = (count_r == {CW{1'b0}});
    busy_s     = (state_r != ST_IDLE);
    bit_end_s  = (baud_cnt_r == 16'd0);
    head_s     = fifo_mem_r[rd_ptr_r];
    push_req_s = wr_s & (in_addr == 2'd0) & in_byte_en[0];
    ovf_clr_s  = wr_s & (in_addr == 2'd1) & in_byte_en[0] & in_write_data[3];
    // The FSM samples empty before this cycle's push, so push-into-empty never pops
    pop_s      = tx_en_r & ~empty_s &
                 ((state_r == ST_IDLE) | ((state_r == ST_STOP) & bit_end_s));
    push_s     = push_req_s & (~full_s | pop_s);
    ovf_set_s  = push_req_s & full_s & ~pop_s;
  end

  // BAUDDIV byte-lane merge with zero clamped to one
  always_comb begin
    baud_merge_s = baud_div_r;
    if (in_byte_en[0]) begin
      baud_merge_s[7:0] = in_write_data[7:0];
    end else begin
      baud_merge_s[7:0] = baud_div_r[7:0];
    end
    if (in_byte_en[1]) begin
      baud_merge_s[15:8] = in_write_data[15:8];
    end else begin
      baud_merge_s[15:8] = baud_div_r[15:8];
    end
    if (baud_merge_s == 16'd0) begin
      baud_wr_s = 16'd1;
    end else begin
      baud_wr_s = baud_merge_s;
    end
  end

  // Configuration registers and sticky overflow flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      baud_div_r <= BAUD_DIV_RESET[15:0];
      tx_en_r    <= 1'b0;
      irq_en_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s && (in_addr == 2'd2)) begin
        baud_div_r <= baud_wr_s;
      end
      if (wr_s && (in_addr == 2'd3) && in_byte_en[0]) begin
        tx_en_r  <= in_write_data[0];
        irq_en_r <= in_write_data[1];
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_write_data[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // TX FSM state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // TX FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_r == 3'd0)) begin
          state_nx_s = ST_STOP;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_end_s && pop_s) begin
          state_nx_s = ST_START;
        end else if (bit_end_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Bit timer, bit counter and shifter; the timer reloads from BAUDDIV at each boundary
  always_comb begin
    shift_nx_s    = shift_r;
    bit_cnt_nx_s  = bit_cnt_r;
    baud_cnt_nx_s = baud_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          shift_nx_s    = head_s;
          bit_cnt_nx_s  = 3'd7;
          baud_cnt_nx_s = baud_div_r - 16'd1;
        end else begin
          baud_cnt_nx_s = baud_cnt_r;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_cnt_nx_s = baud_div_r - 16'd1;
        end else begin
          baud_cnt_nx_s = baud_cnt_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_cnt_nx_s = baud_div_r - 16'd1;
          if (bit_cnt_r != 3'd0) begin
            shift_nx_s   = {1'b0, shift_r[7:1]};
            bit_cnt_nx_s = bit_cnt_r - 3'd1;
          end else begin
            bit_cnt_nx_s = bit_cnt_r;
          end
        end else begin
          baud_cnt_nx_s = baud_cnt_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_cnt_nx_s = baud_div_r - 16'd1;
          if (pop_s) begin
            shift_nx_s   = head_s;
            bit_cnt_nx_s = 3'd7;
          end else begin
            bit_cnt_nx_s = bit_cnt_r;
          end
        end else begin
          baud_cnt_nx_s = baud_cnt_r - 16'd1;
        end
      end
      default: baud_cnt_nx_s = 16'd0;
    endcase
  end

  // Output logic: line level follows the upcoming state so out_tx stays a flop
  always_comb begin
    tx_nx_s = 1'b1;
    case (state_nx_s)
      ST_START: tx_nx_s = 1'b0;
      ST_DATA:  tx_nx_s = shift_nx_s[0];
      default:  tx_nx_s = 1'b1;
    endcase
    irq_nx_s = irq_en_r & empty_s & ~busy_s;
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shift_r    <= 8'd0;
      bit_cnt_r  <= 3'd0;
      baud_cnt_r <= 16'd0;
      tx_r       <= 1'b1;
      irq_r      <= 1'b0;
    end else begin
      shift_r    <= shift_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      baud_cnt_r <= baud_cnt_nx_s;
      tx_r       <= tx_nx_s;
      irq_r      <= irq_nx_s;
    end
  end

  // STATUS word assembly
  always_comb begin
    status_s            = 32'd0;
    status_s[0]         = full_s;
    status_s[1]         = empty_s;
    status_s[2]         = busy_s;
    status_s[3]         = overflow_r;
    status_s[8 +: CW]   = count_r;
  end

  // Side-effect-free read mux
  always_comb begin
    out_read_data = 32'd0;
    if (rd_s) begin
      case (in_addr)
        2'd1:    out_read_data = status_s;
        2'd2:    out_read_data = {16'd0, baud_div_r};
        2'd3:    out_read_data = {30'd0, irq_en_r, tx_en_r};
        default: out_read_data = 32'd0;
      endcase
    end else begin
      out_read_data = 32'd0;
    end
  end

  mmio_uart_tx_chk #(.FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .count (count_r),
    .busy  (busy_s),
    .tx    (tx_r),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// Structural invariants of the transmitter.
module mmio_uart_tx_chk #(
  parameter int FIFO_DEPTH = 8
) (
  input logic                        i_clk,
  input logic                        i_rst,
  input logic [$clog2(FIFO_DEPTH):0] count,
  input logic                        busy,
  input logic                        tx,
  input logic                        full,
  input logic                        empty
);

  a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst)
    count <= ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));

  a_idle_line_high: assert property (@(posedge i_clk) disable iff (!i_rst)
    !busy |-> tx);

  a_flags_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst)
    !(full && empty));

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed plus randomized bench for mmio_uart_tx; line activity is compared
// sample-by-sample against a per-clock waveform built from the frame rules.
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        in_sel;
  logic [1:0]  in_addr;
  logic        in_re_web;
  logic [31:0] in_write_data;
  logic [3:0]  in_byte_en;
  logic [31:0] out_read_data;
  logic        out_tx;
  logic        out_irq;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  logic [7:0] model_q[$];

  mmio_uart_tx dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .in_sel        (in_sel),
    .in_addr       (in_addr),
    .in_re_web     (in_re_web),
    .in_write_data (in_write_data),
    .in_byte_en    (in_byte_en),
    .out_read_data (out_read_data),
    .out_tx        (out_tx),
    .out_irq       (out_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge i_clk);
    in_sel = 1'b1; in_re_web = 1'b0; in_addr = a; in_write_data = d; in_byte_en = be;
    @(negedge i_clk);
    in_sel = 1'b0; in_re_web = 1'b1; in_byte_en = 4'd0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge i_clk);
    in_sel = 1'b1; in_re_web = 1'b1; in_addr = a;
    #1;
    check(tag, out_read_data, exp);
    in_sel = 1'b0;
  endtask

  function automatic logic [31:0] status_model(input int n, input bit ovf, input bit busy);
    logic [31:0] s;
    s = 32'(n) << 8;
    s[0] = (n == DEPTH);
    s[1] = (n == 0);
    s[2] = busy;
    s[3] = ovf;
    return s;
  endfunction

  // Expected line level per clock: start 0, data LSB first, stop 1, bdiv clocks each.
  task automatic add_frame(input logic [7:0] b, input int bdiv, input bit skip_start);
    logic v;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == 9) v = 1'b1;
      else v = b[i-1];
      if (!(skip_start && i == 0)) begin
        for (int k = 0; k < bdiv; k++) exp_q.push_back(v);
      end
    end
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (out_tx !== 1'b0 && lat < 400) begin
      @(negedge i_clk);
      lat++;
    end
    check("frame_start", 32'(out_tx), 32'd0);
  endtask

  task automatic run_wave(input string tag, input bit chk_irq);
    logic v;
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      check(tag, 32'(out_tx), 32'(v));
      if (chk_irq) check("irq_in_frame", 32'(out_irq), 32'd0);
      @(negedge i_clk);
    end
  endtask

  initial begin
    int lat;
    int bdiv;
    int n;
    logic [7:0] b;
    logic [3:0] be;

    i_rst = 1'b0; in_sel = 1'b0; in_re_web = 1'b1; in_addr = 2'd0;
    in_write_data = 32'd0; in_byte_en = 4'd0;
    repeat (3) @(negedge i_clk);
    check("rst_tx", 32'(out_tx), 32'd1);
    check("rst_irq", 32'(out_irq), 32'd0);
    check("rst_rdata", out_read_data, 32'd0);
    i_rst = 1'b1;

    // 1: reset register values
    read_check("t1_status", 2'd1, 32'h0000_0002);
    read_check("t1_baud", 2'd2, 32'h0000_0010);
    read_check("t1_ctrl", 2'd3, 32'h0000_0000);
    check("t1_tx", 32'(out_tx), 32'd1);
    check("t1_irq", 32'(out_irq), 32'd0);

    // 2: single 0xA5 frame at 4 clocks per bit
    bus_write(2'd2, 32'd4, 4'hF);
    bus_write(2'd3, 32'd1, 4'hF);
    bus_write(2'd0, 32'h0000_00A5, 4'h1);
    wait_start(lat);
    check("t2_latency", 32'(lat), 32'd1);
    add_frame(8'hA5, 4, 1'b0);
    check("t2_len", 32'(exp_q.size()), 32'd40);
    run_wave("t2_frame", 1'b0);
    read_check("t2_status_after", 2'd1, 32'h0000_0002);

    // 2b: busy visible mid-frame
    bus_write(2'd0, 32'h0000_003C, 4'h1);
    wait_start(lat);
    read_check("t2b_busy", 2'd1, status_model(0, 1'b0, 1'b1));
    repeat (45) @(negedge i_clk);
    read_check("t2b_idle", 2'd1, status_model(0, 1'b0, 1'b0));

    // 3: overflow, W1C, back-to-back drain
    bus_write(2'd3, 32'd0, 4'hF);
    model_q.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      if (model_q.size() < DEPTH) model_q.push_back(b);
      bus_write(2'd0, {24'd0, b}, 4'h1);
    end
    read_check("t3_ovf", 2'd1, 32'h0000_0809);
    bus_write(2'd1, 32'h0000_0008, 4'h1);
    read_check("t3_w1c", 2'd1, 32'h0000_0801);
    bus_write(2'd3, 32'd1, 4'hF);
    wait_start(lat);
    while (model_q.size() > 0) add_frame(model_q.pop_front(), 4, 1'b0);
    run_wave("t3_burst", 1'b0);
    read_check("t3_drained", 2'd1, 32'h0000_0002);

    // 4: byte lanes, TXDATA read, BAUDDIV clamp
    bus_write(2'd0, 32'h0000_005A, 4'b0010);
    read_check("t4_nopush", 2'd1, 32'h0000_0002);
    read_check("t4_txdata_rd", 2'd0, 32'h0000_0000);
    bus_write(2'd2, 32'd0, 4'hF);
    read_check("t4_clamp", 2'd2, 32'h0000_0001);
    bus_write(2'd2, 32'h0000_1234, 4'b0001);
    read_check("t4_lane", 2'd2, 32'h0000_0034);
    @(negedge i_clk);
    in_sel = 1'b0; in_re_web = 1'b1; in_addr = 2'd2;
    #1 check("t4_unsel_rd", out_read_data, 32'd0);
    bus_write(2'd2, 32'd4, 4'hF);

    // 5: drained interrupt
    bus_write(2'd3, 32'd3, 4'hF);
    check("t5_irq_lat0", 32'(out_irq), 32'd0);
    @(negedge i_clk);
    check("t5_irq_set", 32'(out_irq), 32'd1);
    b = 8'($urandom_range(0, 255));
    bus_write(2'd0, {24'd0, b}, 4'h1);
    check("t5_irq_hold", 32'(out_irq), 32'd1);
    wait_start(lat);
    add_frame(b, 4, 1'b0);
    run_wave("t5_frame", 1'b1);
    check("t5_irq_idle0", 32'(out_irq), 32'd0);
    @(negedge i_clk);
    check("t5_irq_rise", 32'(out_irq), 32'd1);
    bus_write(2'd3, 32'd1, 4'hF);

    // 6a: BAUDDIV change during the start bit applies from the next boundary
    b = 8'($urandom_range(0, 255));
    bus_write(2'd0, {24'd0, b}, 4'h1);
    wait_start(lat);
    bus_write(2'd2, 32'd2, 4'hF);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    add_frame(b, 2, 1'b1);
    run_wave("t6_baudchg", 1'b0);
    read_check("t6_baud_rd", 2'd2, 32'd2);

    // 7: randomized rounds against the queue model
    for (int r = 0; r < 3; r++) begin
      bus_write(2'd3, 32'd0, 4'hF);
      bdiv = int'($urandom_range(1, 5));
      bus_write(2'd2, 32'(bdiv), 4'h3);
      n = int'($urandom_range(1, 8));
      model_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        be = 4'($urandom_range(0, 15));
        if (be[0]) model_q.push_back(b);
        bus_write(2'd0, {24'h5A5A5A, b}, be);
      end
      read_check("t7_status", 2'd1, status_model(model_q.size(), 1'b0, 1'b0));
      bus_write(2'd3, 32'd1, 4'hF);
      if (model_q.size() > 0) begin
        wait_start(lat);
        while (model_q.size() > 0) add_frame(model_q.pop_front(), bdiv, 1'b0);
        run_wave("t7_frames", 1'b0);
      end else begin
        repeat (5) begin
          @(negedge i_clk);
          check("t7_idle_line", 32'(out_tx), 32'd1);
        end
      end
      read_check("t7_drained", 2'd1, 32'h0000_0002);
    end

    // 6b: reset during DATA of a 3-byte burst
    bus_write(2'd3, 32'd0, 4'hF);
    bus_write(2'd2, 32'd4, 4'hF);
    bus_write(2'd0, 32'h0000_0000, 4'h1);
    bus_write(2'd0, 32'h0000_00FF, 4'h1);
    bus_write(2'd0, 32'h0000_0055, 4'h1);
    bus_write(2'd3, 32'd1, 4'hF);
    wait_start(lat);
    repeat (6) @(negedge i_clk);
    check("t6_pre_rst_tx", 32'(out_tx), 32'd0);
    #2 i_rst = 1'b0;
    #1 check("t6_async_tx", 32'(out_tx), 32'd1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    read_check("t6_status", 2'd1, 32'h0000_0002);
    read_check("t6_ctrl", 2'd3, 32'h0000_0000);
    read_check("t6_baud", 2'd2, 32'h0000_0010);
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      check("t6_no_frames", 32'(out_tx), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
